// File: rtl/pulse_stretcher_if.sv
// Request/status bundle for pulse_stretcher: trig goes in; the stretched
// pulse, busy flag, queue depth and drop indication come out.
interface pulse_stretcher_if #(
    parameter int PEND_MAX = 7
);
    localparam int PEND_W = $clog2(PEND_MAX + 1);

    logic              trig;
    logic              pulse_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output trig,
        input  pulse_out,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  trig,
        output pulse_out,
        output busy,
        output pending,
        output overflow
    );
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches each trig request into an ON_CYCLES-wide pulse followed by at least
// OFF_CYCLES low, queueing up to PEND_MAX requests that arrive meanwhile.
module pulse_stretcher #(
    parameter int ON_CYCLES  = 256,
    parameter int OFF_CYCLES = 256,
    parameter int PEND_MAX   = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    pulse_stretcher_if.slave   bus
);
    localparam int CNT_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PEND_W  = $clog2(PEND_MAX + 1);

    localparam logic [CNT_W-1:0]  ON_LOAD   = CNT_W'(ON_CYCLES);
    localparam logic [CNT_W-1:0]  OFF_LOAD  = CNT_W'(OFF_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [PEND_W-1:0] pend_q;
    logic              pulse_q;
    logic              busy_q;
    logic              ovf_q;
    logic              armed_q;

    logic trig_v;
    logic last_cnt;
    logic off_end;
    logic pend_nz;
    logic pend_full;
    logic consume_pend;
    logic consume_trig;

    // armed_q masks trig on the first edge after reset release
    assign trig_v       = bus.trig & armed_q;
    assign last_cnt     = (cnt_q == CNT_ONE);
    assign off_end      = (state_q == OFF) && last_cnt;
    assign pend_nz      = (pend_q != '0);
    assign pend_full    = (pend_q == PEND_FULL);
    assign consume_pend = off_end && pend_nz;
    assign consume_trig = off_end && !pend_nz && trig_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            ovf_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (trig_v) begin
                        state_q <= ON;
                        cnt_q   <= ON_LOAD;
                        pulse_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ON: begin
                    if (last_cnt) begin
                        state_q <= OFF;
                        cnt_q   <= OFF_LOAD;
                        pulse_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                OFF: begin
                    if (last_cnt) begin
                        if (pend_nz || trig_v) begin
                            state_q <= ON;
                            cnt_q   <= ON_LOAD;
                            pulse_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    pulse_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase

            // A trig coinciding with a queue pop replaces the popped entry
            if (consume_pend) begin
                if (!trig_v) begin
                    pend_q <= pend_q - PEND_ONE;
                end
            end else if (trig_v && (state_q != IDLE) && !consume_trig) begin
                if (!pend_full) begin
                    pend_q <= pend_q + PEND_ONE;
                end else begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.busy      = busy_q;
    assign bus.pending   = pend_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with ON=4, OFF=3, PEND_MAX=2; observed
// word is {pulse_out, busy, pending[1:0], overflow}.
module tb_pulse_stretcher;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pulse_stretcher_if #(.PEND_MAX(2)) bus ();

    pulse_stretcher #(
        .ON_CYCLES (4),
        .OFF_CYCLES(3),
        .PEND_MAX  (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] obs();
        return {bus.pulse_out, bus.busy, bus.pending, bus.overflow};
    endfunction

    task automatic check(input string tag, input logic [4:0] exp);
        logic [4:0] o;
        o = obs();
        checks++;
        assert (o === exp) else begin
            errors++;
            $error("FAIL %s observed=%b required=%b", tag, o, exp);
        end
    endtask

    // drive trig for one cycle, step past the edge, compare
    task automatic cyc(input logic t, input logic [4:0] exp, input string tag);
        bus.trig = t;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    task automatic run(input int n, input logic [4:0] exp, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, exp, tag);
    endtask

    localparam logic [4:0] IDL  = 5'b00000;
    localparam logic [4:0] ON0  = 5'b11000;
    localparam logic [4:0] ON1  = 5'b11010;
    localparam logic [4:0] ON2  = 5'b11100;
    localparam logic [4:0] OF0  = 5'b01000;
    localparam logic [4:0] OF1  = 5'b01010;
    localparam logic [4:0] OF2  = 5'b01100;
    localparam logic [4:0] ON2O = 5'b11101;

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        bus.trig = 1'b0;

        // reset state, trig ignored while reset is low
        @(posedge clk); #1;
        check("reset_state", IDL);
        cyc(1'b1, IDL, "trig_in_reset");
        rst_n = 1'b1;
        cyc(1'b1, IDL, "trig_first_after_release");
        cyc(1'b0, IDL, "idle_after_release");

        // single request
        cyc(1'b1, ON0, "single_rise");
        run(3, ON0, "single_on");
        run(3, OF0, "single_off");
        cyc(1'b0, IDL, "single_idle");

        // three back-to-back requests
        cyc(1'b1, ON0, "q3_start");
        cyc(1'b1, ON1, "q3_pend1");
        cyc(1'b1, ON2, "q3_pend2");
        cyc(1'b0, ON2, "q3_on_last");
        run(3, OF2, "q3_off1");
        cyc(1'b0, ON1, "q3_pulse2_start");
        run(3, ON1, "q3_pulse2_on");
        run(3, OF1, "q3_off2");
        cyc(1'b0, ON0, "q3_pulse3_start");
        run(3, ON0, "q3_pulse3_on");
        run(3, OF0, "q3_off3");
        cyc(1'b0, IDL, "q3_idle");

        // four requests: saturation and one-cycle overflow
        cyc(1'b1, ON0, "q4_start");
        cyc(1'b1, ON1, "q4_pend1");
        cyc(1'b1, ON2, "q4_pend2");
        cyc(1'b1, ON2O, "q4_overflow");
        cyc(1'b0, OF2, "q4_ovf_clear");
        run(2, OF2, "q4_off1");
        cyc(1'b0, ON1, "q4_pulse2_start");
        run(3, ON1, "q4_pulse2_on");
        run(3, OF1, "q4_off2");
        cyc(1'b0, ON0, "q4_pulse3_start");
        run(3, ON0, "q4_pulse3_on");
        run(3, OF0, "q4_off3");
        cyc(1'b0, IDL, "q4_idle");

        // full queue with trig on the final OFF cycle
        cyc(1'b1, ON0, "full_start");
        cyc(1'b1, ON1, "full_pend1");
        cyc(1'b1, ON2, "full_pend2");
        cyc(1'b0, ON2, "full_on_last");
        run(3, OF2, "full_off1");
        cyc(1'b1, ON2, "full_pop_and_push");
        run(3, ON2, "full_pulse2_on");
        run(3, OF2, "full_off2");
        cyc(1'b0, ON1, "full_pulse3_start");
        run(3, ON1, "full_pulse3_on");
        run(3, OF1, "full_off3");
        cyc(1'b0, ON0, "full_pulse4_start");
        run(3, ON0, "full_pulse4_on");
        run(3, OF0, "full_off4");
        cyc(1'b0, IDL, "full_idle");

        // asynchronous reset mid-pulse with a queued request
        cyc(1'b1, ON0, "rst_start");
        cyc(1'b1, ON1, "rst_pend1");
        bus.trig = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", IDL);
        run(2, IDL, "rst_held");
        rst_n = 1'b1;
        run(10, IDL, "rst_no_pulse_after");

        // trig on the last ON cycle with empty queue
        cyc(1'b1, ON0, "late_start");
        run(3, ON0, "late_on");
        cyc(1'b1, OF1, "late_queued");
        run(2, OF1, "late_off");
        cyc(1'b0, ON0, "late_pulse2_start");
        run(3, ON0, "late_pulse2_on");
        run(3, OF0, "late_off2");
        cyc(1'b0, IDL, "late_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
